// File: rtl/lift_plant_emulator.sv
`default_nettype none
// ============================================================================
// Module      : lift_plant_emulator
// Description : Plant model of one lift car. Integrates shaft travel from the
//               motion/direction commands, produces symmetric floor contact
//               windows, models a timed door stroke and latches sticky
//               violation flags for the controller under test.
//               Optional build macro LIFT_EMU_ASSERT_EN adds concurrent
//               assertions that $error on every violation condition and on
//               inconsistent sensor/door outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_plant_emulator #(
  parameter int N_FLOORS     = 12,
  parameter int T_FLOOR      = 200,
  parameter int T_FLR_CONTCT = 50,
  parameter int T_DOOR       = 40,
  parameter int START_FLOOR  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        motion,
  input  logic                        direction,
  input  logic                        door_cmd,
  input  logic                        err_clr,
  output logic [N_FLOORS-1:0]         floor_sense,
  output logic [$clog2(N_FLOORS)-1:0] pos_floor,
  output logic                        moving,
  output logic                        door_open,
  output logic                        door_closed,
  output logic [3:0]                  err_flags
);

  // Widths: floor index, signed offset (must hold +/-T_FLOOR), door counter.
  localparam int c_fw = $clog2(N_FLOORS);
  localparam int c_ow = $clog2(T_FLOOR + 1) + 1;
  localparam int c_dw = $clog2(T_DOOR + 1);

  localparam logic [c_fw-1:0]        c_top        = c_fw'(N_FLOORS - 1);
  localparam logic [c_fw-1:0]        c_floor_one  = c_fw'(1);
  localparam logic [c_fw-1:0]        c_start      = c_fw'(START_FLOOR);
  localparam logic signed [c_ow-1:0] c_unit       = c_ow'(1);
  localparam logic signed [c_ow-1:0] c_step_max   = c_ow'(T_FLOOR - 1);
  localparam logic signed [c_ow-1:0] c_win        = c_ow'(T_FLR_CONTCT);
  localparam logic signed [c_ow-1:0] c_near       = c_ow'(T_FLOOR - T_FLR_CONTCT);
  localparam logic [c_dw-1:0]        c_dc_full    = c_dw'(T_DOOR);
  localparam logic [c_dw-1:0]        c_dc_last    = c_dw'(T_DOOR - 1);
  localparam logic [c_dw-1:0]        c_dc_one     = c_dw'(1);
  localparam logic [N_FLOORS-1:0]    c_one        = N_FLOORS'(1);
  localparam logic [N_FLOORS-1:0]    c_sense_rst  = c_one << START_FLOOR;

  typedef enum logic [1:0] {
    S_CLOSED  = 2'd0,
    S_OPENING = 2'd1,
    S_OPEN    = 2'd2,
    S_CLOSING = 2'd3
  } door_state_t;

  // Car position is floor r_floor plus signed offset r_off in clocks.
  logic [c_fw-1:0]        r_floor;
  logic signed [c_ow-1:0] r_off;
  logic [N_FLOORS-1:0]    r_sense;
  logic                   r_moving;
  logic                   r_prev_motion;
  logic                   r_prev_dir;
  logic [3:0]             r_err;
  door_state_t            r_door;
  logic [c_dw-1:0]        r_dc;

  logic                   w_at_limit;
  logic                   w_step;
  logic [c_fw-1:0]        w_floor;
  logic signed [c_ow-1:0] w_off;
  logic [N_FLOORS-1:0]    w_here;
  logic [N_FLOORS-1:0]    w_sense;
  logic                   w_aligned;
  logic                   w_dir_chg;
  logic                   w_stop_mid;
  logic                   w_overrun;
  logic                   w_door_viol;
  logic [3:0]             w_viol;

  assign w_aligned   = (r_off == '0);
  assign floor_sense = r_sense;
  assign pos_floor   = r_floor;
  assign moving      = r_moving;
  assign err_flags   = r_err;

  // Next position: one clock of travel when the move is accepted, wrapping
  // the offset into the adjacent floor when it reaches a full floor pitch.
  always_comb begin
    w_floor    = r_floor;
    w_off      = r_off;
    w_at_limit = direction ? ((r_floor == c_top) && !r_off[c_ow-1])
                           : ((r_floor == '0) && (r_off[c_ow-1] || w_aligned));
    w_step     = motion && (r_door == S_CLOSED) && !w_at_limit;
    if (w_step) begin
      if (direction) begin
        if (r_off == c_step_max) begin
          w_floor = r_floor + c_floor_one;
          w_off   = '0;
        end else begin
          w_off = r_off + c_unit;
        end
      end else begin
        if (r_off == -c_step_max) begin
          w_floor = r_floor - c_floor_one;
          w_off   = '0;
        end else begin
          w_off = r_off - c_unit;
        end
      end
    end
  end

  // Contact sensor for the post-edge position: a floor is sensed when the
  // car is within the contact half-window on either side of it.
  always_comb begin
    w_sense = '0;
    w_here  = c_one << w_floor;
    if ((w_off <= c_win) && (w_off >= -c_win)) begin
      w_sense = w_here;
    end else if (w_off >= c_near) begin
      w_sense = w_here << 1;
    end else if (w_off <= -c_near) begin
      w_sense = w_here >> 1;
    end
  end

  // Violation detection on the current command against pre-edge state.
  always_comb begin
    w_dir_chg   = r_prev_motion && motion && (r_prev_dir != direction);
    w_stop_mid  = r_prev_motion && !motion && !w_aligned;
    w_overrun   = motion && w_at_limit;
    w_door_viol = (door_cmd && (motion || !w_aligned)) ||
                  (motion && (r_door != S_CLOSED));
    w_viol      = {w_door_viol, w_overrun, w_stop_mid, w_dir_chg};
  end

  // Position, sensor and motion-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_floor       <= c_start;
      r_off         <= '0;
      r_sense       <= c_sense_rst;
      r_moving      <= 1'b0;
      r_prev_motion <= 1'b0;
      r_prev_dir    <= 1'b0;
    end else begin
      r_floor       <= w_floor;
      r_off         <= w_off;
      r_sense       <= w_sense;
      r_moving      <= w_step;
      r_prev_motion <= motion;
      r_prev_dir    <= direction;
    end
  end

  // Sticky error flags; a new violation wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 4'b0000;
    end else begin
      r_err <= (err_clr ? 4'b0000 : r_err) | w_viol;
    end
  end

  // Door stroke FSM; a reversed command turns the stroke around at the
  // current counter value so the door retraces from where it is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_door      <= S_CLOSED;
      r_dc        <= '0;
      door_open   <= 1'b0;
      door_closed <= 1'b1;
    end else begin
      case (r_door)
        S_CLOSED: begin
          if (door_cmd && !motion && w_aligned) begin
            r_door      <= S_OPENING;
            door_closed <= 1'b0;
          end
        end
        S_OPENING: begin
          if (!door_cmd) begin
            r_door <= S_CLOSING;
          end else if (r_dc >= c_dc_last) begin
            r_dc      <= c_dc_full;
            r_door    <= S_OPEN;
            door_open <= 1'b1;
          end else begin
            r_dc <= r_dc + c_dc_one;
          end
        end
        S_OPEN: begin
          if (!door_cmd) begin
            r_door    <= S_CLOSING;
            door_open <= 1'b0;
          end
        end
        S_CLOSING: begin
          if (door_cmd) begin
            r_door <= S_OPENING;
          end else if (r_dc <= c_dc_one) begin
            r_dc        <= '0;
            r_door      <= S_CLOSED;
            door_closed <= 1'b1;
          end else begin
            r_dc <= r_dc - c_dc_one;
          end
        end
        default: begin
          r_door      <= S_CLOSED;
          r_dc        <= '0;
          door_open   <= 1'b0;
          door_closed <= 1'b1;
        end
      endcase
    end
  end

`ifdef LIFT_EMU_ASSERT_EN
  a_dir_chg: assert property (@(posedge clk) disable iff (rst) !w_dir_chg)
    else $error("lift_plant_emulator: direction changed while moving");
  a_stop_mid: assert property (@(posedge clk) disable iff (rst) !w_stop_mid)
    else $error("lift_plant_emulator: car stopped between floors");
  a_overrun: assert property (@(posedge clk) disable iff (rst) !w_overrun)
    else $error("lift_plant_emulator: travel requested past shaft limit");
  a_door: assert property (@(posedge clk) disable iff (rst) !w_door_viol)
    else $error("lift_plant_emulator: door/motion interlock violated");
  a_sense: assert property (@(posedge clk) disable iff (rst) $onehot0(floor_sense))
    else $error("lift_plant_emulator: floor_sense not one-hot");
  a_door_excl: assert property (@(posedge clk) disable iff (rst) !(door_open && door_closed))
    else $error("lift_plant_emulator: door both open and closed");
`endif

endmodule
`default_nettype wire

// File: tb/tb_lift_plant_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_plant_emulator
// Description : Self-checking bench for lift_plant_emulator. An absolute
//               position reference model predicts every output per edge and
//               pushes it to a scoreboard; the DUT result is popped and
//               compared after the edge. Directed spot checks cover the
//               sensor windows, limits, interlocks and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_plant_emulator;

  localparam int N  = 12;
  localparam int TF = 200;
  localparam int TC = 50;
  localparam int TD = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        motion;
  logic        direction;
  logic        door_cmd;
  logic        err_clr;
  logic [11:0] floor_sense;
  logic [3:0]  pos_floor;
  logic        moving;
  logic        door_open;
  logic        door_closed;
  logic [3:0]  err_flags;

  always #5 clk = ~clk;

  lift_plant_emulator #(
    .N_FLOORS    (N),
    .T_FLOOR     (TF),
    .T_FLR_CONTCT(TC),
    .T_DOOR      (TD),
    .START_FLOOR (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .motion     (motion),
    .direction  (direction),
    .door_cmd   (door_cmd),
    .err_clr    (err_clr),
    .floor_sense(floor_sense),
    .pos_floor  (pos_floor),
    .moving     (moving),
    .door_open  (door_open),
    .door_closed(door_closed),
    .err_flags  (err_flags)
  );

  typedef struct packed {
    logic [11:0] sense;
    logic [3:0]  pos;
    logic        mv;
    logic        dop;
    logic        dcl;
    logic [3:0]  err;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  // Reference model: absolute height in clocks above ground.
  int         m_pos;
  int         m_last;
  int         m_dstate;  // 0 closed, 1 opening, 2 open, 3 closing
  int         m_dc;
  logic       m_pm;
  logic       m_pd;
  logic [3:0] m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pos = 0; m_last = 0; m_dstate = 0; m_dc = 0;
    m_pm = 1'b0; m_pd = 1'b0; m_err = 4'b0000;
    sb.delete();
  endtask

  task automatic model_edge(input logic mot, input logic dir, input logic dcmd,
                            input logic clr, output exp_t e);
    bit         aligned;
    bit         lim;
    bit         go;
    int         k;
    int         d;
    logic [3:0] v;
    aligned = (m_pos % TF) == 0;
    lim     = dir ? (m_pos >= (N - 1) * TF) : (m_pos <= 0);
    go      = mot && (m_dstate == 0) && !lim;
    v[0]    = m_pm && mot && (m_pd != dir);
    v[1]    = m_pm && !mot && !aligned;
    v[2]    = mot && lim;
    v[3]    = (dcmd && (mot || !aligned)) || (mot && (m_dstate != 0));
    m_err   = (clr ? 4'b0000 : m_err) | v;
    case (m_dstate)
      0: if (dcmd && !mot && aligned) m_dstate = 1;
      1: if (!dcmd) m_dstate = 3;
         else begin
           m_dc++;
           if (m_dc >= TD) begin m_dc = TD; m_dstate = 2; end
         end
      2: if (!dcmd) m_dstate = 3;
      default: if (dcmd) m_dstate = 1;
         else begin
           m_dc--;
           if (m_dc <= 0) begin m_dc = 0; m_dstate = 0; end
         end
    endcase
    if (go) m_pos += dir ? 1 : -1;
    if ((m_pos % TF) == 0) m_last = m_pos / TF;
    k = (m_pos + TF / 2) / TF;
    d = m_pos - k * TF;
    e       = '0;
    if (d <= TC && d >= -TC) e.sense[k] = 1'b1;
    e.pos   = 4'(m_last);
    e.mv    = go;
    e.dop   = (m_dstate == 2);
    e.dcl   = (m_dstate == 0);
    e.err   = m_err;
    m_pm    = mot;
    m_pd    = dir;
  endtask

  // One clock: drive on the falling edge, predict, then compare after the rise.
  task automatic step(input logic mot, input logic dir, input logic dcmd, input logic clr);
    exp_t e;
    exp_t x;
    @(negedge clk);
    motion = mot; direction = dir; door_cmd = dcmd; err_clr = clr;
    model_edge(mot, dir, dcmd, clr, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("sense", 32'(floor_sense), 32'(x.sense));
    check("pos",   32'(pos_floor),   32'(x.pos));
    check("mv",    32'(moving),      32'(x.mv));
    check("dopen", 32'(door_open),   32'(x.dop));
    check("dclsd", 32'(door_closed), 32'(x.dcl));
    check("err",   32'(err_flags),   32'(x.err));
  endtask

  task automatic run(input int n, input logic mot, input logic dir, input logic dcmd);
    for (int i = 0; i < n; i++) step(mot, dir, dcmd, 1'b0);
  endtask

  // Asynchronous reset away from any clock edge; outputs must follow at once.
  task automatic apply_reset();
    #2;
    motion = 1'b0; direction = 1'b0; door_cmd = 1'b0; err_clr = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_sense", 32'(floor_sense), 32'h001);
    check("rst_pos",   32'(pos_floor),   32'h0);
    check("rst_mv",    32'(moving),      32'h0);
    check("rst_dopen", 32'(door_open),   32'h0);
    check("rst_dclsd", 32'(door_closed), 32'h1);
    check("rst_err",   32'(err_flags),   32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; motion = 1'b0; direction = 1'b0; door_cmd = 1'b0; err_clr = 1'b0;
    model_reset();
    apply_reset();

    // Up travel across the first floor pitch and its contact windows.
    phase = "t1";
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 50)  check("o50",  32'(floor_sense), 32'h001);
      if (k == 51)  check("o51",  32'(floor_sense), 32'h000);
      if (k == 149) check("o149", 32'(floor_sense), 32'h000);
      if (k == 150) check("o150", 32'(floor_sense), 32'h002);
      if (k == 200) check("pos1", 32'(pos_floor),   32'h1);
    end

    // Continue to the top floor, then request past the upper limit.
    phase = "t2";
    run(2000, 1'b1, 1'b1, 1'b0);
    check("top", 32'(pos_floor), 32'd11);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ovr_mv",  32'(moving),    32'h0);
    check("ovr_err", 32'(err_flags), 32'b0100);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("clr", 32'(err_flags), 32'h0);

    // Stop mid-shaft between floors 2 and 3, hold, then resume.
    phase = "t3";
    apply_reset();
    run(500, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("stop_err",   32'(err_flags),   32'b0010);
    check("stop_sense", 32'(floor_sense), 32'h000);
    check("stop_pos",   32'(pos_floor),   32'h2);
    run(3, 1'b0, 1'b1, 1'b0);
    run(100, 1'b1, 1'b1, 1'b0);
    check("arrive3", 32'(pos_floor), 32'h3);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Door open stroke at floor 3, interlock, reversal and re-close.
    phase = "t4";
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("dc_drop", 32'(door_closed), 32'h0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 39) check("open39", 32'(door_open), 32'h0);
      if (i == 40) check("open40", 32'(door_open), 32'h1);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("intlk_mv",  32'(moving),    32'h0);
    check("intlk_err", 32'(err_flags), 32'b1000);
    run(16, 1'b0, 1'b1, 1'b0);
    run(5,  1'b0, 1'b1, 1'b1);
    run(60, 1'b0, 1'b1, 1'b0);
    check("reclosed", 32'(door_closed), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("simul_mv",  32'(moving),    32'h1);
    check("simul_err", 32'(err_flags), 32'b1000);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Direction reversal mid-travel, return to ground, then under-run.
    phase = "t5";
    apply_reset();
    run(80, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("dchg_err", 32'(err_flags), 32'b0001);
    run(79, 1'b1, 1'b0, 1'b0);
    check("back_sense", 32'(floor_sense), 32'h001);
    check("back_pos",   32'(pos_floor),   32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("under_mv",  32'(moving),    32'h0);
    check("under_err", 32'(err_flags), 32'b0101);

    // Asynchronous reset mid-travel and mid door stroke.
    phase = "t6";
    apply_reset();
    run(120, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    apply_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run(20, 1'b0, 1'b1, 1'b1);
    apply_reset();
    run(3, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
